// File: rtl/setassoc_cache_ctrl.sv
// N-way set-associative read cache controller: tree-PLRU replacement, per-line invalidate, sequenced flush.
// Optional macro CACHE_STATS_EN adds wrapping stat_reads/stat_hits/stat_misses counters.
module setassoc_cache_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int WORD_W     = 32,
  parameter int SETS       = 64,
  parameter int WAYS       = 4,
  parameter int LINE_WORDS = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_hit,
  output logic [WORD_W-1:0] rsp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rdata_valid,
  input  logic [WORD_W-1:0] mem_rdata,
`ifdef CACHE_STATS_EN
  output logic [31:0]       stat_reads,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses,
`endif
  output logic [2:0]        state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high; the
  // sender holds valid and payload stable until then. mem_rdata_valid beats have no backpressure.

  localparam int OFF_W    = $clog2(WORD_W / 8);
  localparam int WIDX_W   = $clog2(LINE_WORDS);
  localparam int SET_W    = $clog2(SETS);
  localparam int WAY_W    = $clog2(WAYS);
  localparam int LINE_LSB = OFF_W + WIDX_W;
  localparam int TAG_LSB  = LINE_LSB + SET_W;
  localparam int TAG_W    = ADDR_W - TAG_LSB;
  localparam int CNT_W    = (SET_W > WIDX_W) ? SET_W : WIDX_W;

  localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(SETS - 1);

  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_INV   = 2'b10;
  localparam logic [1:0] OP_FLUSH = 2'b11;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    FILL_REQ  = 3'd2,
    FILL_DATA = 3'd3,
    FLUSH     = 3'd4,
    RESP      = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [1:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WAY_W-1:0]  victim_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              rsp_hit_q;
  logic [WORD_W-1:0] rsp_data_q;

  logic [SETS-1:0][WAYS-1:0] valid_q;
  logic [SETS-1:0][WAYS-2:0] plru_q;
  logic [TAG_W-1:0]          tag_mem  [SETS][WAYS];
  logic [WORD_W-1:0]         data_mem [SETS][WAYS][LINE_WORDS];

  logic [SET_W-1:0]  set_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [WIDX_W-1:0] word_idx;
  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic              inv_found;
  logic [WAY_W-1:0]  inv_way;
  logic [WAY_W-1:0]  miss_victim;
  logic              fill_last;
  logic              flush_last;
  logic              addr_unused;

  // Tree walk: node n has children 2n/2n+1, bit (n-1) = 1 means the LRU side is the right child.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] bits);
    int node;
    node = 1;
    for (int l = 0; l < WAY_W; l++) node = 2 * node + int'(bits[node-1]);
    return WAY_W'(node - WAYS);
  endfunction

  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits,
                                                 input logic [WAY_W-1:0] way);
    logic [WAYS-2:0] r;
    logic            dir;
    int              node;
    r    = bits;
    node = 1;
    for (int l = 0; l < WAY_W; l++) begin
      dir         = way[WAY_W-1-l];
      r[node-1]   = ~dir;
      node        = 2 * node + int'(dir);
    end
    return r;
  endfunction

  assign set_idx     = addr_q[LINE_LSB +: SET_W];
  assign req_tag     = addr_q[TAG_LSB +: TAG_W];
  assign word_idx    = addr_q[OFF_W +: WIDX_W];
  assign addr_unused = ^addr_q;

  // Lowest-index wins for both the (unique) match and the first free way.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[set_idx][w] && (tag_mem[set_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[set_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    miss_victim = inv_found ? inv_way : plru_victim(plru_q[set_idx]);
  end

  assign fill_last  = mem_rdata_valid && (cnt_q == FILL_LAST);
  assign flush_last = (cnt_q == FLUSH_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    mem_req_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if ((req_op == OP_READ) || (req_op == OP_INV)) state_d = LOOKUP;
          else if (req_op == OP_FLUSH)                   state_d = FLUSH;
        end
      end
      LOOKUP:    state_d = ((op_q == OP_READ) && !hit) ? FILL_REQ : RESP;
      FILL_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = FILL_DATA;
      end
      FILL_DATA: if (fill_last) state_d = RESP;
      FLUSH:     if (flush_last) state_d = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_q       <= '0;
      addr_q     <= '0;
      victim_q   <= '0;
      cnt_q      <= '0;
      rsp_hit_q  <= 1'b0;
      rsp_data_q <= '0;
      valid_q    <= '0;
      plru_q     <= '0;
`ifdef CACHE_STATS_EN
      stat_reads  <= '0;
      stat_hits   <= '0;
      stat_misses <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            op_q   <= req_op;
            addr_q <= req_addr;
            cnt_q  <= '0;
          end
        end
        LOOKUP: begin
          if (op_q == OP_READ) begin
`ifdef CACHE_STATS_EN
            stat_reads <= stat_reads + 32'd1;
            if (hit) stat_hits   <= stat_hits + 32'd1;
            else     stat_misses <= stat_misses + 32'd1;
`endif
            if (hit) begin
              rsp_hit_q       <= 1'b1;
              rsp_data_q      <= data_mem[set_idx][hit_way][word_idx];
              plru_q[set_idx] <= plru_touch(plru_q[set_idx], hit_way);
            end else begin
              victim_q <= miss_victim;
            end
          end else begin
            rsp_hit_q  <= hit;
            rsp_data_q <= '0;
            if (hit) valid_q[set_idx][hit_way] <= 1'b0;
          end
        end
        FILL_DATA: begin
          if (mem_rdata_valid) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (fill_last) begin
              cnt_q                     <= '0;
              valid_q[set_idx][victim_q] <= 1'b1;
              plru_q[set_idx]           <= plru_touch(plru_q[set_idx], victim_q);
              rsp_hit_q                 <= 1'b0;
              // The requested word is either this final beat or one already stored.
              rsp_data_q <= (CNT_W'(word_idx) == FILL_LAST) ? mem_rdata
                                                            : data_mem[set_idx][victim_q][word_idx];
            end
          end
        end
        FLUSH: begin
          valid_q[cnt_q[SET_W-1:0]] <= '0;
          cnt_q <= cnt_q + CNT_W'(1);
          if (flush_last) begin
            cnt_q      <= '0;
            plru_q     <= '0;
            rsp_hit_q  <= 1'b0;
            rsp_data_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag and data arrays carry no reset; valid bits alone qualify them.
  always_ff @(posedge clock) begin
    if ((state_q == FILL_DATA) && mem_rdata_valid) begin
      data_mem[set_idx][victim_q][cnt_q[WIDX_W-1:0]] <= mem_rdata;
      if (fill_last) tag_mem[set_idx][victim_q] <= req_tag;
    end
  end

  assign rsp_hit      = rsp_hit_q;
  assign rsp_data     = rsp_data_q;
  assign mem_req_addr = {addr_q[ADDR_W-1:LINE_LSB], {LINE_LSB{1'b0}}};
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_setassoc_cache_ctrl.sv
// Directed bench for setassoc_cache_ctrl: fills, hits, PLRU eviction, invalidate, flush, reset mid-fill.
// Build with CACHE_STATS_EN defined to also cover the statistics counters.
module tb_setassoc_cache_ctrl;
  localparam int ADDR_W = 32, WORD_W = 32, SETS = 64, WAYS = 4, LINE_WORDS = 16;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [1:0]        req_op = 2'b00;
  logic [ADDR_W-1:0] req_addr = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic              rsp_hit;
  logic [WORD_W-1:0] rsp_data;
  logic              mem_req_valid;
  logic              mem_req_ready = 1'b1;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_rdata_valid = 1'b0;
  logic [WORD_W-1:0] mem_rdata = '0;
  logic [2:0]        state_dbg;
`ifdef CACHE_STATS_EN
  logic [31:0]       stat_reads, stat_hits, stat_misses;
`endif

  localparam logic [1:0] NOP = 2'b00, RD = 2'b01, INV = 2'b10, FLS = 2'b11;

  int checks = 0;
  int failures = 0;

  // next-level memory model state
  int          mem_wait = 0;
  int          wait_cnt = 0;
  int          beats_left = 0;
  int          beat_idx = 0;
  int          beats_sent = 0;
  int          fill_reqs = 0;
  logic [31:0] fill_base = 32'hA000_0000;
  logic [31:0] last_fill_addr = '0;
  logic [31:0] exp_q[$];

  setassoc_cache_ctrl #(
    .ADDR_W(ADDR_W), .WORD_W(WORD_W), .SETS(SETS), .WAYS(WAYS), .LINE_WORDS(LINE_WORDS)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit), .rsp_data(rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
`ifdef CACHE_STATS_EN
    .stat_reads(stat_reads), .stat_hits(stat_hits), .stat_misses(stat_misses),
`endif
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Memory responder: ready after mem_wait cycles of valid, then LINE_WORDS beats, word n = fill_base+n.
  initial begin : mem_model
    forever begin
      @(negedge clock);
      if (beats_left > 0) begin
        mem_rdata_valid = 1'b1;
        mem_rdata       = fill_base + 32'(beat_idx);
        beat_idx++;
        beats_sent++;
        beats_left--;
      end else begin
        mem_rdata_valid = 1'b0;
      end
      if (mem_req_valid && reset_n) begin
        if (wait_cnt >= mem_wait) begin
          mem_req_ready  = 1'b1;
          fill_reqs++;
          last_fill_addr = mem_req_addr;
          beats_left     = LINE_WORDS;
          beat_idx       = 0;
          beats_sent     = 0;
          wait_cnt       = 0;
        end else begin
          mem_req_ready = 1'b0;
          wait_cnt++;
        end
      end else begin
        mem_req_ready = (mem_wait == 0);
        wait_cnt      = 0;
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    beats_left = 0;
    mem_rdata_valid = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  // Called at a negedge with the controller idle. lat counts edges, the handshake edge being 1.
  task automatic cpu_txn(input logic [1:0] op, input logic [31:0] addr, input int hold,
                         output logic hit, output logic [31:0] data, output int lat,
                         output logic stable, output logic done);
    hit = 1'b0; data = '0; lat = 0; stable = 1'b1; done = 1'b0;
    req_valid = 1'b1; req_op = op; req_addr = addr; rsp_ready = (hold == 0);
    @(negedge clock);
    lat = 1; req_valid = 1'b0; req_op = NOP;
    while (!rsp_valid && lat < 300) begin
      @(negedge clock);
      lat++;
    end
    if (rsp_valid) begin
      done = 1'b1; hit = rsp_hit; data = rsp_data;
      for (int i = 0; i < hold; i++) begin
        @(negedge clock);
        if (!rsp_valid || rsp_hit !== hit || rsp_data !== data) stable = 1'b0;
      end
      rsp_ready = 1'b1;
      @(negedge clock);
    end
    rsp_ready = 1'b1;
  endtask

  // scenarios
  task automatic test_reset();
    repeat (3) @(negedge clock);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%0b exp=1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%0b exp=0", rsp_valid); end
    checks++; if (rsp_hit !== 1'b0) begin failures++; $display("FAIL reset_rsp_hit got=%0b exp=0", rsp_hit); end
    checks++; if (rsp_data !== 32'h0) begin failures++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
    checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_mem_req_valid got=%0b exp=0", mem_req_valid); end
    checks++; if (mem_req_addr !== 32'h0) begin failures++; $display("FAIL reset_mem_req_addr got=%h exp=0", mem_req_addr); end
    checks++; if (state_dbg !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_miss_fill();
    logic hit, stable, done; logic [31:0] data; int lat, f0;
    f0 = fill_reqs; fill_base = 32'hA000_0000; mem_wait = 0;
    cpu_txn(RD, 32'h0000_1004, 0, hit, data, lat, stable, done);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL miss_done got=%0b exp=1", done); end
    checks++; if (hit !== 1'b0) begin failures++; $display("FAIL miss_hit got=%0b exp=0", hit); end
    checks++; if (data !== 32'hA000_0001) begin failures++; $display("FAIL miss_data got=%h exp=a0000001", data); end
    checks++; if (lat != 19) begin failures++; $display("FAIL miss_latency got=%0d exp=19", lat); end
    checks++; if (fill_reqs != f0 + 1) begin failures++; $display("FAIL miss_fill_count got=%0d exp=%0d", fill_reqs, f0 + 1); end
    checks++; if (last_fill_addr !== 32'h0000_1000) begin failures++; $display("FAIL miss_fill_addr got=%h exp=00001000", last_fill_addr); end
  endtask

  task automatic test_hit();
    logic hit, stable, done; logic [31:0] data; int lat, f0;
    f0 = fill_reqs;
    cpu_txn(RD, 32'h0000_1008, 3, hit, data, lat, stable, done);
    checks++; if (hit !== 1'b1) begin failures++; $display("FAIL hit_hit got=%0b exp=1", hit); end
    checks++; if (data !== 32'hA000_0002) begin failures++; $display("FAIL hit_data got=%h exp=a0000002", data); end
    checks++; if (lat != 2) begin failures++; $display("FAIL hit_latency got=%0d exp=2", lat); end
    checks++; if (stable !== 1'b1) begin failures++; $display("FAIL hit_rsp_stable got=%0b exp=1", stable); end
    cpu_txn(RD, 32'h0000_103C, 0, hit, data, lat, stable, done);
    checks++; if (hit !== 1'b1 || data !== 32'hA000_000F) begin failures++; $display("FAIL hit_last_word got=%0b/%h exp=1/a000000f", hit, data); end
    checks++; if (fill_reqs != f0) begin failures++; $display("FAIL hit_no_fill got=%0d exp=%0d", fill_reqs, f0); end
`ifdef CACHE_STATS_EN
    checks++; if (stat_reads !== 32'd3) begin failures++; $display("FAIL stat_reads got=%0d exp=3", stat_reads); end
    checks++; if (stat_hits !== 32'd2) begin failures++; $display("FAIL stat_hits got=%0d exp=2", stat_hits); end
    checks++; if (stat_misses !== 32'd1) begin failures++; $display("FAIL stat_misses got=%0d exp=1", stat_misses); end
`endif
  endtask

  task automatic test_nop();
    logic bad;
    bad = 1'b0;
    req_valid = 1'b1; req_op = NOP; req_addr = 32'h0000_1004;
    @(negedge clock);
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || state_dbg !== 3'd0) bad = 1'b1;
      @(negedge clock);
    end
    checks++; if (bad !== 1'b0) begin failures++; $display("FAIL nop_dropped got=%0b exp=0", bad); end
  endtask

  task automatic test_plru_evict();
    logic hit, stable, done; logic [31:0] data, exp; int lat;
    do_reset();
    for (int t = 1; t <= 5; t++) begin
      fill_base = 32'hB000_0000 + 32'(t << 8);
      mem_wait  = (t == 5) ? 3 : 0;
      cpu_txn(RD, 32'(t << 12), 0, hit, data, lat, stable, done);
      checks++; if (hit !== 1'b0 || data !== fill_base) begin failures++; $display("FAIL plru_fill%0d got=%0b/%h exp=0/%h", t, hit, data, fill_base); end
    end
    checks++; if (lat != 22) begin failures++; $display("FAIL plru_wait_latency got=%0d exp=22", lat); end
    mem_wait = 0;
    for (int t = 2; t <= 5; t++) exp_q.push_back(32'hB000_0000 + 32'(t << 8));
    for (int t = 2; t <= 5; t++) begin
      exp = exp_q.pop_front();
      cpu_txn(RD, 32'(t << 12), 0, hit, data, lat, stable, done);
      checks++; if (hit !== 1'b1 || data !== exp) begin failures++; $display("FAIL plru_keep%0d got=%0b/%h exp=1/%h", t, hit, data, exp); end
    end
    cpu_txn(RD, 32'h0000_1000, 0, hit, data, lat, stable, done);
    checks++; if (hit !== 1'b0) begin failures++; $display("FAIL plru_evicted got=%0b exp=0", hit); end
  endtask

  task automatic test_invalidate();
    logic hit, stable, done; logic [31:0] data; int lat, f0;
    do_reset();
    fill_base = 32'hD000_0000;
    cpu_txn(RD, 32'h0000_1000, 0, hit, data, lat, stable, done);
    cpu_txn(RD, 32'h0000_1040, 0, hit, data, lat, stable, done);
    cpu_txn(INV, 32'h0000_1000, 0, hit, data, lat, stable, done);
    checks++; if (hit !== 1'b1 || data !== 32'h0) begin failures++; $display("FAIL inv_present got=%0b/%h exp=1/0", hit, data); end
    checks++; if (lat != 2) begin failures++; $display("FAIL inv_latency got=%0d exp=2", lat); end
    cpu_txn(INV, 32'h0000_1000, 0, hit, data, lat, stable, done);
    checks++; if (hit !== 1'b0) begin failures++; $display("FAIL inv_absent got=%0b exp=0", hit); end
    cpu_txn(RD, 32'h0000_1040, 0, hit, data, lat, stable, done);
    checks++; if (hit !== 1'b1) begin failures++; $display("FAIL inv_other_set got=%0b exp=1", hit); end
    f0 = fill_reqs;
    cpu_txn(RD, 32'h0000_1000, 0, hit, data, lat, stable, done);
    checks++; if (hit !== 1'b0 || fill_reqs != f0 + 1) begin failures++; $display("FAIL inv_read_miss got=%0b/%0d exp=0/%0d", hit, fill_reqs, f0 + 1); end
  endtask

  task automatic test_flush();
    logic hit, stable, done, fhit; logic [31:0] data, fdata; int lat, low_cnt, rsp_lat;
    cpu_txn(RD, 32'h0000_0FC0, 0, hit, data, lat, stable, done);
    low_cnt = 0; rsp_lat = 0; fhit = 1'b1; fdata = 32'hFFFF_FFFF;
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_op = FLS; req_addr = 32'h0;
    @(negedge clock);
    req_op = NOP;
    for (int c = 1; c <= 100; c++) begin
      if (req_ready) break;
      low_cnt++;
      if (rsp_valid && rsp_lat == 0) begin rsp_lat = c; fhit = rsp_hit; fdata = rsp_data; end
      @(negedge clock);
    end
    req_valid = 1'b0;
    @(negedge clock);
    checks++; if (low_cnt != 65) begin failures++; $display("FAIL flush_req_ready_low got=%0d exp=65", low_cnt); end
    checks++; if (rsp_lat != 65) begin failures++; $display("FAIL flush_latency got=%0d exp=65", rsp_lat); end
    checks++; if (fhit !== 1'b0 || fdata !== 32'h0) begin failures++; $display("FAIL flush_rsp got=%0b/%h exp=0/0", fhit, fdata); end
    cpu_txn(RD, 32'h0000_1040, 0, hit, data, lat, stable, done);
    checks++; if (hit !== 1'b0) begin failures++; $display("FAIL flush_set1_miss got=%0b exp=0", hit); end
    cpu_txn(RD, 32'h0000_0FC0, 0, hit, data, lat, stable, done);
    checks++; if (hit !== 1'b0) begin failures++; $display("FAIL flush_set63_miss got=%0b exp=0", hit); end
    cpu_txn(RD, 32'h0000_1000, 0, hit, data, lat, stable, done);
    checks++; if (hit !== 1'b0) begin failures++; $display("FAIL flush_set0_miss got=%0b exp=0", hit); end
  endtask

  task automatic test_reset_mid_fill();
    logic hit, stable, done, reached; logic [31:0] data; int lat, f0;
    mem_wait = 0; fill_base = 32'hE000_0000; reached = 1'b0;
    req_valid = 1'b1; req_op = RD; req_addr = 32'h0000_3008;
    @(negedge clock);
    req_valid = 1'b0; req_op = NOP;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (beats_sent >= 8) begin reached = 1'b1; break; end
    end
    checks++; if (reached !== 1'b1) begin failures++; $display("FAIL midfill_beats got=%0d exp>=8", beats_sent); end
    reset_n = 1'b0; beats_left = 0; mem_rdata_valid = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1 || state_dbg !== 3'd0 || mem_req_valid !== 1'b0) begin failures++; $display("FAIL midfill_async_reset got=%0b/%0d/%0b exp=1/0/0", req_ready, state_dbg, mem_req_valid); end
    repeat (2) @(negedge clock);
`ifdef CACHE_STATS_EN
    checks++; if (stat_reads !== 32'd0 || stat_hits !== 32'd0 || stat_misses !== 32'd0) begin failures++; $display("FAIL stats_after_reset got=%0d/%0d/%0d exp=0/0/0", stat_reads, stat_hits, stat_misses); end
`endif
    reset_n = 1'b1;
    @(negedge clock);
    f0 = fill_reqs; fill_base = 32'hC000_0000;
    cpu_txn(RD, 32'h0000_3008, 0, hit, data, lat, stable, done);
    checks++; if (hit !== 1'b0 || data !== 32'hC000_0002) begin failures++; $display("FAIL midfill_reread got=%0b/%h exp=0/c0000002", hit, data); end
    checks++; if (fill_reqs != f0 + 1 || last_fill_addr !== 32'h0000_3000) begin failures++; $display("FAIL midfill_refill got=%0d/%h exp=%0d/00003000", fill_reqs, last_fill_addr, f0 + 1); end
  endtask

  initial begin : main
    test_reset();
    test_miss_fill();
    test_hit();
    test_nop();
    test_plru_evict();
    test_invalidate();
    test_flush();
    test_reset_mid_fill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
